// File: rtl/exe_pkg.sv
// ============================================================================
// Module   : exe_pkg
// Purpose  : Shared opcode encodings, FSM state type and multiplier
//            iteration count for the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package exe_pkg;

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0100;
    localparam logic [3:0] CMD_OR  = 4'b0101;
    localparam logic [3:0] CMD_NOR = 4'b0110;
    localparam logic [3:0] CMD_XOR = 4'b0111;
    localparam logic [3:0] CMD_SLL = 4'b1000;
    localparam logic [3:0] CMD_SRA = 4'b1001;
    localparam logic [3:0] CMD_SRL = 4'b1010;
    localparam logic [3:0] CMD_MUL = 4'b1100;

    localparam int MUL_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } exe_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_mult.sv
// ============================================================================
// Module   : seq_mult
// Purpose  : Iterative shift-add multiplier, one multiplier bit per cycle,
//            always MUL_ITERS iterations; returns the low 32 product bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mult
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    localparam logic [4:0] C_LAST_ITER = 5'(MUL_ITERS - 1);

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_acc;
    logic [4:0]  r_count;
    logic        r_busy;
    logic [31:0] w_acc_next;

    assign w_acc_next = r_acc + (r_b[0] ? r_a : 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
        end else if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            r_acc   <= w_acc_next;
            r_a     <= r_a << 1;
            r_b     <= r_b >> 1;
            r_count <= r_count + 5'd1;
            if (r_count == C_LAST_ITER) begin
                r_busy <= 1'b0;
            end
        end
    end

    // The final iteration's sum is exposed combinationally so the caller can
    // register the product on the same edge that completes it.
    assign busy    = r_busy;
    assign done    = r_busy && (r_count == C_LAST_ITER);
    assign product = r_busy ? w_acc_next : r_acc;

endmodule

`default_nettype wire

// File: rtl/exe_stage.sv
// ============================================================================
// Module   : exe_stage
// Purpose  : Pipeline execute stage: ALU plus registered results toward the
//            memory stage. Define EXE_MULT_EN to build the iterative MUL unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exe_stage
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  EXE_CMD,
    input  logic [31:0] val1,
    input  logic [31:0] val2,
    input  logic [31:0] ST_val_in,
    input  logic        MEM_R_EN_in,
    input  logic        MEM_W_EN_in,
    input  logic        WB_EN_in,
    input  logic [4:0]  dest_in,
    input  logic        mem_freeze,
    output logic        exe_freeze,
    output logic        out_valid,
    output logic [31:0] ALU_result,
    output logic [31:0] ST_val,
    output logic        MEM_R_EN,
    output logic        MEM_W_EN,
    output logic        WB_EN,
    output logic [4:0]  dest
);

    logic [31:0] w_alu;
    logic [4:0]  w_shamt;
    logic        w_accept;
    logic        w_load_alu;
    logic        w_load_mult;
    logic [31:0] w_mult_result;
    logic [31:0] w_mult_st;
    logic [7:0]  w_mult_ctl;

    logic        r_out_valid;
    logic [31:0] r_result;
    logic [31:0] r_st_val;
    logic        r_mem_r;
    logic        r_mem_w;
    logic        r_wb;
    logic [4:0]  r_dest;

    assign w_shamt = val2[4:0];

    // MUL falls to the default arm: it yields 0 here and is produced by the
    // multiplier path when that is built.
    always_comb begin
        w_alu = '0;
        case (EXE_CMD)
            CMD_ADD: w_alu = val1 + val2;
            CMD_SUB: w_alu = val1 - val2;
            CMD_AND: w_alu = val1 & val2;
            CMD_OR:  w_alu = val1 | val2;
            CMD_NOR: w_alu = ~(val1 | val2);
            CMD_XOR: w_alu = val1 ^ val2;
            CMD_SLL: w_alu = val1 << w_shamt;
            CMD_SRA: w_alu = $signed(val1) >>> w_shamt;
            CMD_SRL: w_alu = val1 >> w_shamt;
            default: w_alu = '0;
        endcase
    end

`ifdef EXE_MULT_EN
    exe_state_t  r_state;
    exe_state_t  w_state_next;
    logic        w_is_mul;
    logic        w_mult_start;
    logic        w_mult_busy;
    logic        w_mult_done;
    logic [31:0] w_product;
    logic [31:0] r_pend_st;
    logic [7:0]  r_pend_ctl;

    assign w_is_mul     = (EXE_CMD == CMD_MUL);
    assign w_accept     = (r_state == IDLE) && in_valid && !mem_freeze;
    assign w_load_alu   = w_accept && !w_is_mul;
    assign w_mult_start = w_accept && w_is_mul;

    seq_mult u_seq_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mult_start),
        .a       (val1),
        .b       (val2),
        .busy    (w_mult_busy),
        .done    (w_mult_done),
        .product (w_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_mult_start) w_state_next = BUSY;
            BUSY:    if (w_mult_done)  w_state_next = mem_freeze ? DONE : IDLE;
            DONE:    if (!mem_freeze)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Upstream stops holding its inputs after accept, so the passthrough
    // fields of a MUL are captured here for the deferred result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_st  <= '0;
            r_pend_ctl <= '0;
        end else if (w_mult_start) begin
            r_pend_st  <= ST_val_in;
            r_pend_ctl <= {MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, dest_in};
        end
    end

    assign w_load_mult   = !mem_freeze &&
                           (((r_state == BUSY) && w_mult_done) || (r_state == DONE));
    assign w_mult_result = w_product;
    assign w_mult_st     = r_pend_st;
    assign w_mult_ctl    = r_pend_ctl;
    assign exe_freeze    = mem_freeze || (r_state != IDLE) || w_mult_busy ||
                           ((r_state == IDLE) && in_valid && w_is_mul);
`else
    assign w_accept      = in_valid && !mem_freeze;
    assign w_load_alu    = w_accept;
    assign w_load_mult   = 1'b0;
    assign w_mult_result = '0;
    assign w_mult_st     = '0;
    assign w_mult_ctl    = '0;
    assign exe_freeze    = mem_freeze;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_st_val    <= '0;
            r_mem_r     <= 1'b0;
            r_mem_w     <= 1'b0;
            r_wb        <= 1'b0;
            r_dest      <= '0;
        end else if (!mem_freeze) begin
            if (w_load_alu) begin
                r_out_valid <= 1'b1;
                r_result    <= w_alu;
                r_st_val    <= ST_val_in;
                {r_mem_r, r_mem_w, r_wb, r_dest} <= {MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, dest_in};
            end else if (w_load_mult) begin
                r_out_valid <= 1'b1;
                r_result    <= w_mult_result;
                r_st_val    <= w_mult_st;
                {r_mem_r, r_mem_w, r_wb, r_dest} <= w_mult_ctl;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign ALU_result = r_result;
    assign ST_val     = r_st_val;
    assign MEM_R_EN   = r_mem_r;
    assign MEM_W_EN   = r_mem_w;
    assign WB_EN      = r_wb;
    assign dest       = r_dest;

endmodule

`default_nettype wire

// File: tb/tb_exe_stage.sv
// ============================================================================
// Module   : tb_exe_stage
// Purpose  : Scoreboard bench for exe_stage; expectations follow the build
//            selected by EXE_MULT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exe_stage;

`ifdef EXE_MULT_EN
    localparam bit C_MULT = 1'b1;
`else
    localparam bit C_MULT = 1'b0;
`endif
    localparam int C_MUL_LAT    = C_MULT ? 33 : 1;
    localparam int C_MUL_FRZ    = C_MULT ? 33 : 0;
    localparam int C_MUL_FZ_LAT = C_MULT ? 38 : 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  EXE_CMD = '0;
    logic [31:0] val1 = '0, val2 = '0, ST_val_in = '0;
    logic        MEM_R_EN_in = 1'b0, MEM_W_EN_in = 1'b0, WB_EN_in = 1'b0;
    logic [4:0]  dest_in = '0;
    logic        mem_freeze = 1'b0;
    logic        exe_freeze, out_valid;
    logic [31:0] ALU_result, ST_val;
    logic        MEM_R_EN, MEM_W_EN, WB_EN;
    logic [4:0]  dest;

    exe_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .EXE_CMD(EXE_CMD),
        .val1(val1), .val2(val2), .ST_val_in(ST_val_in),
        .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .WB_EN_in(WB_EN_in),
        .dest_in(dest_in), .mem_freeze(mem_freeze), .exe_freeze(exe_freeze),
        .out_valid(out_valid), .ALU_result(ALU_result), .ST_val(ST_val),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN), .dest(dest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] st;
        logic [7:0]  ctl;
        int          lat;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic mf_edge  = 1'b0;
    logic rst_edge = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: return a + b;
            4'b0010: return a - b;
            4'b0100: return a & b;
            4'b0101: return a | b;
            4'b0110: return ~(a | b);
            4'b0111: return a ^ b;
            4'b1000: return a << b[4:0];
            4'b1001: return $signed(a) >>> b[4:0];
            4'b1010: return a >> b[4:0];
            4'b1100: return C_MULT ? a * b : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        mf_edge  <= mem_freeze;
        rst_edge <= rst;
    end

    // A freshly registered result appears only after an edge with neither
    // reset nor mem_freeze; held values under a stall are not new results.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_edge && !mf_edge && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("alu_result", ALU_result, e.res);
                check_eq("st_val", ST_val, e.st);
                check_eq("ctl_dest", {24'd0, MEM_R_EN, MEM_W_EN, WB_EN, dest}, {24'd0, e.ctl});
                check_eq("latency", 32'(cyc - e.cyc), 32'(e.lat));
            end
        end
    end

    // Called at posedge+2; presents one instruction for the cycle and
    // returns at the next posedge+2 with in_valid dropped.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input bit push, output logic fz0);
        exp_t e;
        EXE_CMD   = c;
        val1      = a;
        val2      = b;
        ST_val_in = $urandom;
        {MEM_R_EN_in, MEM_W_EN_in, WB_EN_in} = 3'($urandom);
        dest_in   = 5'($urandom);
        in_valid  = 1'b1;
        e.res = model(c, a, b);
        e.st  = ST_val_in;
        e.ctl = {MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, dest_in};
        e.lat = lat;
        e.cyc = cyc;
        if (push) sb.push_back(e);
        #1;
        fz0 = exe_freeze;
        if (lat == 1) check_eq("exe_freeze_on_issue", {31'd0, exe_freeze}, 32'd0);
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            step(1);
            n++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic        fz;
        logic [31:0] held;
        int          nfz;

        step(2);
        rst = 1'b0;
        #1;
        check_eq("reset_valid", {31'd0, out_valid}, 32'd0);
        check_eq("reset_result", ALU_result, 32'd0);
        check_eq("reset_misc", {ST_val[26:0], MEM_R_EN, MEM_W_EN, WB_EN, dest[1:0]}, 32'd0);
        check_eq("reset_freeze", {31'd0, exe_freeze}, 32'd0);
        #1;

        // Wrap-around ADD/SUB back-to-back, then shift corners
        issue(4'b0000, 32'h7FFF_FFFF, 32'd1, 1, 1'b1, fz);
        issue(4'b0010, 32'd0, 32'd1, 1, 1'b1, fz);
        issue(4'b1001, 32'h8000_0000, 32'd4, 1, 1'b1, fz);
        issue(4'b1000, 32'd1, 32'd36, 1, 1'b1, fz);
        drain();

        // Every non-MUL code, two random operand pairs each, back-to-back
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 16; c++) begin
                if (c != 12) issue(4'(c), $urandom, $urandom, 1, 1'b1, fz);
            end
        end
        drain();

        // Stall holds a valid result; release clears out_valid only
        issue(4'b0111, 32'hA5A5_0000, 32'h0F0F_F0F0, 1, 1'b1, fz);
        held = 32'hA5A5_0000 ^ 32'h0F0F_F0F0;
        mem_freeze = 1'b1;
        EXE_CMD = 4'b0000; val1 = 32'd5; val2 = 32'd5; in_valid = 1'b1;
        #1;
        check_eq("freeze_follows_mem", {31'd0, exe_freeze}, 32'd1);
        step(1);
        check_eq("stall_hold_valid", {31'd0, out_valid}, 32'd1);
        check_eq("stall_hold_result", ALU_result, held);
        step(1);
        check_eq("stall_hold_valid2", {31'd0, out_valid}, 32'd1);
        mem_freeze = 1'b0;
        in_valid   = 1'b0;
        step(1);
        check_eq("idle_clears_valid", {31'd0, out_valid}, 32'd0);
        check_eq("idle_holds_result", ALU_result, held);

        // MUL without stall: freeze length and latency
        issue(4'b1100, 32'hFFFF_FFFF, 32'd3, C_MUL_LAT, 1'b1, fz);
        nfz = fz ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            in_valid = (i < 5);
            EXE_CMD = 4'b0000; val1 = 32'd9; val2 = 32'd9;
            #1;
            if (!exe_freeze) break;
            nfz++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq("mul_freeze_cycles", 32'(nfz), 32'(C_MUL_FRZ));
        drain();
        step(2);

        // MUL 6*7 with mem_freeze over cycles C+30..C+36
        issue(4'b1100, 32'd6, 32'd7, C_MUL_FZ_LAT, 1'b1, fz);
        step(29);
        mem_freeze = 1'b1;
        step(4);
        check_eq("done_hold_valid", {31'd0, out_valid}, 32'd0);
        check_eq("done_freeze", {31'd0, exe_freeze}, 32'd1);
        step(3);
        mem_freeze = 1'b0;
        drain();
        step(2);

        // Reset mid-MUL discards the product
        issue(4'b1100, 32'd9, 32'd9, 1, !C_MULT, fz);
        step(9);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        #1;
        check_eq("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_mid_result", ALU_result, 32'd0);
        check_eq("rst_mid_st", ST_val, 32'd0);
        check_eq("rst_mid_ctl", {27'd0, MEM_R_EN, MEM_W_EN, WB_EN, dest[1:0]}, 32'd0);
        check_eq("rst_mid_freeze", {31'd0, exe_freeze}, 32'd0);
        #1;
        step(40);
        issue(4'b0000, 32'd2, 32'd2, 1, 1'b1, fz);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
